// File: rtl/hrm_slink_rxbuf.sv
// hrm_slink_rxbuf: slink-side receive frame buffer.
// Stores decoded link words and exposes only complete, CRC-good frames to the MM read port.
// Frames are committed (cptr advance) or discarded (wptr rewind) atomically.
// Optional build macro HRM_RXBUF_STAT_EN adds stat_pkt_ok / stat_pkt_drop counters.
module hrm_slink_rxbuf #(
  parameter int unsigned BUF_AW      = 10,
  parameter int unsigned MAX_PKT_LEN = 512,
  parameter int unsigned PKT_CW      = 8
) (
  input  logic        clk_100m,
  input  logic        rst_100m,
  input  logic        lnk_rx_dval,
  input  logic [17:0] lnk_rx_data,
  input  logic        lnk_rx_eop,
  input  logic        lnk_rx_err,
  input  logic        mm_slink_rdreq,
  output logic        slink_mm_empty,
  output logic        slink_mm_dval,
  output logic [17:0] slink_mm_data,
`ifdef HRM_RXBUF_STAT_EN
  output logic [15:0] stat_pkt_ok,
  output logic [15:0] stat_pkt_drop,
`endif
  output logic        rxbuf_drop
);

  localparam int unsigned Depth = 2 ** BUF_AW;
  localparam int unsigned LenW  = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

  state_e              state_q;
  logic [BUF_AW-1:0]   wptr_q, cptr_q, rptr_q;
  logic [LenW-1:0]     len_q;
  logic [PKT_CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                empty_q, dval_q, drop_q;
  logic [17:0]         data_q;
  logic [18:0]         mem [Depth];

  logic [BUF_AW-1:0]   free, wptr_inc;
  logic [LenW-1:0]     len_nxt;
  logic                accept, full, too_long, pkt_sat;
  logic                do_write, do_commit, do_abort, do_overflow, drop_evt;
  logic                rd_en, rd_eop;

  // Write-side decode: classify the incoming word against space, length and counter limits.
  always_comb begin
    free        = rptr_q - wptr_q - BUF_AW'(1);
    wptr_inc    = wptr_q + BUF_AW'(1);
    len_nxt     = (state_q == StIdle) ? LenW'(1) : len_q + LenW'(1);
    accept      = lnk_rx_dval && (state_q != StDrop);
    full        = (free == '0);
    too_long    = (len_nxt == LenW'(MAX_PKT_LEN)) && !lnk_rx_eop;
    pkt_sat     = (pkt_cnt_q == '1);
    do_write    = accept && !full;
    do_commit   = do_write && lnk_rx_eop && !lnk_rx_err && !pkt_sat;
    // eop of a frame that cannot be kept: discard now and pulse
    do_abort    = accept && lnk_rx_eop && (full || lnk_rx_err || pkt_sat);
    // frame dies mid-way: discard now, pulse later when its eop shows up
    do_overflow = accept && !lnk_rx_eop && (full || too_long);
    drop_evt    = do_abort || ((state_q == StDrop) && lnk_rx_dval && lnk_rx_eop);
  end

  // Read-side decode: never read past the last committed word.
  always_comb begin
    rd_en  = mm_slink_rdreq && !empty_q && (rptr_q != cptr_q);
    rd_eop = mem[rptr_q][18];
  end

  // Committed-frame count; a commit and an eop read in the same cycle cancel.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (do_commit && !(rd_en && rd_eop)) begin
      pkt_cnt_d = pkt_cnt_q + PKT_CW'(1);
    end else if (!do_commit && rd_en && rd_eop) begin
      pkt_cnt_d = pkt_cnt_q - PKT_CW'(1);
    end
  end

  // Word storage; contents are not reset.
  always_ff @(posedge clk_100m) begin
    if (do_write) begin
      mem[wptr_q] <= {lnk_rx_eop, lnk_rx_data};
    end
  end

  // Write FSM: pointer advance, commit and rewind.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      cptr_q  <= '0;
      len_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= drop_evt;
      case (state_q)
        StIdle, StRecv: begin
          if (lnk_rx_dval) begin
            if (do_overflow) begin
              wptr_q  <= cptr_q;
              state_q <= StDrop;
            end else if (do_abort) begin
              wptr_q  <= cptr_q;
              state_q <= StIdle;
            end else if (do_commit) begin
              wptr_q  <= wptr_inc;
              cptr_q  <= wptr_inc;
              state_q <= StIdle;
            end else begin
              wptr_q  <= wptr_inc;
              len_q   <= len_nxt;
              state_q <= StRecv;
            end
          end
        end
        StDrop: begin
          if (lnk_rx_dval && lnk_rx_eop) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read port: one-cycle latency, back-to-back capable.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      rptr_q <= '0;
      dval_q <= 1'b0;
      data_q <= '0;
    end else begin
      dval_q <= rd_en;
      if (rd_en) begin
        data_q <= mem[rptr_q][17:0];
        rptr_q <= rptr_q + BUF_AW'(1);
      end
    end
  end

  // Frame counter and registered empty flag.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      pkt_cnt_q <= '0;
      empty_q   <= 1'b1;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      empty_q   <= (pkt_cnt_d == '0);
    end
  end

`ifdef HRM_RXBUF_STAT_EN
  logic [15:0] stat_ok_q, stat_drop_q;

  // Wrapping statistics counters.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      stat_ok_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      if (do_commit) stat_ok_q <= stat_ok_q + 16'd1;
      if (drop_evt)  stat_drop_q <= stat_drop_q + 16'd1;
    end
  end

  assign stat_pkt_ok   = stat_ok_q;
  assign stat_pkt_drop = stat_drop_q;
`endif

  assign slink_mm_empty = empty_q;
  assign slink_mm_dval  = dval_q;
  assign slink_mm_data  = data_q;
  assign rxbuf_drop     = drop_q;

endmodule

// File: tb/tb_hrm_slink_rxbuf.sv
// Bench for hrm_slink_rxbuf: small buffer (16 words), MAX_PKT_LEN=8, 2-bit frame counter.
// Reference model keeps committed words and the frame in flight as queues.
module tb_hrm_slink_rxbuf;

  localparam int unsigned AW     = 4;
  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CW     = 2;
  localparam int          DEPTH  = 16;
  localparam int          MAXCNT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lnk_rx_dval = 1'b0;
  logic [17:0] lnk_rx_data = '0;
  logic        lnk_rx_eop = 1'b0;
  logic        lnk_rx_err = 1'b0;
  logic        mm_slink_rdreq = 1'b0;
  logic        slink_mm_empty, slink_mm_dval, rxbuf_drop;
  logic [17:0] slink_mm_data;
`ifdef HRM_RXBUF_STAT_EN
  logic [15:0] stat_pkt_ok, stat_pkt_drop;
`endif

  always #5 clk = ~clk;

  hrm_slink_rxbuf #(.BUF_AW(AW), .MAX_PKT_LEN(MAXLEN), .PKT_CW(CW)) dut (
    .clk_100m       (clk),
    .rst_100m       (rst),
    .lnk_rx_dval    (lnk_rx_dval),
    .lnk_rx_data    (lnk_rx_data),
    .lnk_rx_eop     (lnk_rx_eop),
    .lnk_rx_err     (lnk_rx_err),
    .mm_slink_rdreq (mm_slink_rdreq),
    .slink_mm_empty (slink_mm_empty),
    .slink_mm_dval  (slink_mm_dval),
    .slink_mm_data  (slink_mm_data),
`ifdef HRM_RXBUF_STAT_EN
    .stat_pkt_ok    (stat_pkt_ok),
    .stat_pkt_drop  (stat_pkt_drop),
`endif
    .rxbuf_drop     (rxbuf_drop)
  );

  // {empty, dval, data, drop}
  logic [20:0] obs;
  assign obs = {slink_mm_empty, slink_mm_dval, slink_mm_data, rxbuf_drop};
  localparam logic [20:0] IdleV = {1'b1, 1'b0, 18'h0, 1'b0};

  int unsigned ncmp = 0;
  int unsigned nfail = 0;

  // Reference model state
  logic [18:0] q_com[$];
  logic [18:0] q_cur[$];
  int          frames;
  bit          dropping;
  logic [17:0] exp_data;
  logic [20:0] exp_v;

  task automatic model_reset();
    q_com.delete();
    q_cur.delete();
    frames   = 0;
    dropping = 0;
    exp_data = '0;
    exp_v    = IdleV;
  endtask

  // Predict outputs after the coming clock edge from the inputs now applied.
  task automatic model_step();
    int          fb = frames;
    bit          drop_now = 0;
    bit          rd_v = 0;
    logic [18:0] w;
    if (lnk_rx_dval) begin
      if (dropping) begin
        if (lnk_rx_eop) begin
          dropping = 0;
          drop_now = 1;
        end
      end else if (DEPTH - 1 - q_com.size() - q_cur.size() == 0) begin
        q_cur.delete();
        if (lnk_rx_eop) drop_now = 1;
        else dropping = 1;
      end else begin
        q_cur.push_back({lnk_rx_eop, lnk_rx_data});
        if (lnk_rx_eop) begin
          if (lnk_rx_err || fb == MAXCNT) begin
            drop_now = 1;
          end else begin
            foreach (q_cur[k]) q_com.push_back(q_cur[k]);
            frames++;
          end
          q_cur.delete();
        end else if (q_cur.size() == MAXLEN) begin
          q_cur.delete();
          dropping = 1;
        end
      end
    end
    if (mm_slink_rdreq && fb > 0) begin
      w        = q_com.pop_front();
      rd_v     = 1;
      exp_data = w[17:0];
      if (w[18]) frames--;
    end
    exp_v = {(frames == 0), rd_v, exp_data, drop_now};
  endtask

  task automatic drive(input bit dv, input logic [17:0] d, input bit e, input bit er,
                       input bit rd);
    lnk_rx_dval    = dv;
    lnk_rx_data    = d;
    lnk_rx_eop     = e;
    lnk_rx_err     = er;
    mm_slink_rdreq = rd;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two cycles with whatever inputs are currently applied.
  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    lnk_rx_dval = 0; lnk_rx_data = '0; lnk_rx_eop = 0; lnk_rx_err = 0; mm_slink_rdreq = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    ncmp++;
    if (obs !== IdleV) begin
      nfail++;
      $display("FAIL reset_state: got %h want %h", obs, IdleV);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 18'(i), i == 4, 0, 0);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL basic_wr[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
    ncmp++;
    if (slink_mm_empty !== 1'b0) begin
      nfail++;
      $display("FAIL basic_empty_after_commit: got %b want 0", slink_mm_empty);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(0, '0, 0, 0, i <= 4);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL basic_rd[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_err_frame();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 18'(32'h100 + i), i == 3, i == 3, 0);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL err_wr[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      if (i <= 2) drive(1, 18'(32'h200 + i), i == 2, 0, 0);
      else drive(0, '0, 0, 0, i <= 5);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL err_next[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  // Fill with an unread 8-word frame, then overflow with two more frames.
  task automatic test_overflow();
    int n = 0;
    int lens[3] = '{8, 8, 20};
    foreach (lens[f]) begin
      for (int i = 1; i <= lens[f]; i++) begin
        drive(1, 18'($urandom), i == lens[f], 0, 0);
        n++;
        ncmp++;
        if (obs !== exp_v) begin
          nfail++;
          $display("FAIL ovf_wr[%0d]: got %h want %h", n, obs, exp_v);
        end
      end
    end
    for (int i = 1; i <= 16; i++) begin
      if (i >= 10 && i <= 12) drive(1, 18'(32'h300 + i), i == 12, 0, 0);
      else drive(0, '0, 0, 0, i <= 8 || i >= 13);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL ovf_rd[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_maxlen();
    int n = 0;
    int lens[2] = '{9, 8};
    foreach (lens[f]) begin
      for (int i = 1; i <= lens[f]; i++) begin
        drive(1, 18'(32'h400 + 16 * f + i), i == lens[f], 0, 0);
        n++;
        ncmp++;
        if (obs !== exp_v) begin
          nfail++;
          $display("FAIL maxlen_wr[%0d]: got %h want %h", n, obs, exp_v);
        end
      end
    end
    for (int i = 1; i <= 10; i++) begin
      drive(0, '0, 0, 0, 1);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL maxlen_rd[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  // Frame B's eop commits in the same cycle frame A's eop word is read.
  task automatic test_commit_and_read();
    drive(1, 18'h0A1, 0, 0, 0);
    drive(1, 18'h0A2, 1, 0, 0);
    drive(1, 18'h0B1, 0, 0, 1);
    ncmp++;
    if (obs !== exp_v) begin
      nfail++;
      $display("FAIL simul_rd_a1: got %h want %h", obs, exp_v);
    end
    drive(1, 18'h0B2, 1, 0, 1);
    ncmp++;
    if (obs !== exp_v) begin
      nfail++;
      $display("FAIL simul_commit_rd: got %h want %h", obs, exp_v);
    end
    ncmp++;
    if (slink_mm_empty !== 1'b0 || slink_mm_data !== 18'h0A2) begin
      nfail++;
      $display("FAIL simul_empty_held: got empty=%b data=%h want empty=0 data=0a2",
               slink_mm_empty, slink_mm_data);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, '0, 0, 0, i <= 2);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL simul_rd_b[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 18'h501, 0, 0, 0);
    drive(1, 18'h502, 1, 0, 0);
    drive(1, 18'h503, 0, 0, 1);
    lnk_rx_dval = 1; lnk_rx_data = 18'h504; mm_slink_rdreq = 1;
    apply_reset();
    ncmp++;
    if (obs !== IdleV) begin
      nfail++;
      $display("FAIL reset_mid_state: got %h want %h", obs, IdleV);
    end
    for (int i = 1; i <= 5; i++) begin
      if (i <= 2) drive(1, 18'(32'h600 + i), i == 2, 0, 0);
      else drive(0, '0, 0, 0, 1);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL reset_mid_next[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    int left = 0;
    bit ferr = 0;
    bit dv, e, er, rd;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      dv = 0; e = 0;
      if (left == 0 && $urandom_range(0, 3) == 0) begin
        left = $urandom_range(1, 11);
        ferr = ($urandom_range(0, 7) == 0);
      end
      if (left > 0 && $urandom_range(0, 3) != 0) begin
        dv = 1;
        left--;
        e = (left == 0);
      end
      er = e ? ferr : 1'($urandom_range(0, 1));
      rd = $urandom_range(0, 99) < ((cyc < 1500) ? 20 : 70);
      drive(dv, 18'($urandom), e, er, rd);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL random[%0d]: got %h want %h", cyc, obs, exp_v);
      end
    end
    for (int i = 0; i < 40; i++) begin
      drive(0, '0, 0, 0, 1);
      ncmp++;
      if (obs !== exp_v) begin
        nfail++;
        $display("FAIL random_drain[%0d]: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_err_frame();
    test_overflow();
    test_maxlen();
    test_commit_and_read();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
